aes_key_sched: RTL and testbench

Iterative, parametrised AES key-schedule engine for AES-128, AES-192 and AES-256, selected per key by a mode input.
- It accepts a cipher key on a start handshake and expands it one 32-bit word per cycle into an internal round-key store.
- It then serves 128-bit round keys by round index through a registered read port.
- It sits between the key-load interface and the round datapath, and replaces the fully unrolled 128-bit-only expansion pipeline with a single reusable word engine.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_key_sched_if.sv | 28 ++
 rtl/aes_sbox_word.sv | 11 +
 rtl/aes_key_sched.sv | 181 ++++++++++++++++++
 tb/tb_aes_key_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the key-schedule engine:
// S-box lookup, GF(2^8) doubling and per-mode word/round counts.
package aes_pkg;

    localparam int RK_W = 128;

    typedef enum logic [1:0] {
        AES128 = 2'd0,
        AES192 = 2'd1,
        AES256 = 2'd2
    } aes_mode_e;

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[11'd2040 - {b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            AES192:  return 4'd6;
            AES256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            AES192:  return 4'd12;
            AES256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-load and round-key read bus between the key source and the schedule engine.
interface aes_key_sched_if #(
    parameter int MAX_KEY_BITS = 256
);
    import aes_pkg::*;

    logic                    start;
    logic [1:0]              key_mode;
    logic [MAX_KEY_BITS-1:0] key;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    rk_valid;
    logic [3:0]              nr;
    logic [3:0]              rk_idx;
    logic [RK_W-1:0]         rk;

    modport master (
        output start, key_mode, key, rk_idx,
        input  busy, done, err, rk_valid, nr, rk
    );

    modport slave (
        input  start, key_mode, key, rk_idx,
        output busy, done, err, rk_valid, nr, rk
    );

endinterface

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key expansion, one 32-bit word per cycle into a
// register store, with a registered round-key read port.
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic           clk,
    input  logic           rst,
    aes_key_sched_if.slave bus
);

    localparam int KEY_WORDS = MAX_KEY_BITS / 32;
    localparam int NR_MAX    = KEY_WORDS + 6;
    localparam int DEPTH     = 4 * (NR_MAX + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_EXPAND = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [5:0]      i_q, i_d;
    logic [2:0]      phase_q, phase_d;
    logic [7:0]      rcon_q, rcon_d;
    logic [3:0]      nk_q, nk_d;
    logic [3:0]      nr_q, nr_d;
    logic            rk_valid_q, rk_valid_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [RK_W-1:0] rk_q, rk_d;
    logic [31:0]     store_q [DEPTH];
    logic [31:0]     store_d [DEPTH];

    logic        mode_ok;
    logic        load_key;
    logic        wr_word;
    logic [5:0]  last_idx;
    logic [5:0]  rd_base;
    logic [31:0] prev_w;
    logic [31:0] back_w;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_w;
    logic [31:0] new_w;

    assign mode_ok  = (bus.key_mode != 2'd3) && (int'(nk_of(bus.key_mode)) <= KEY_WORDS);
    assign last_idx = {nr_q, 2'b00} + 6'd3;

    // ---- word engine: w[i] = w[i-Nk] ^ f(w[i-1]) ----
    always_comb begin
        prev_w = store_q[i_q - 6'd1];
        sub_in = (phase_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    end

    aes_sbox_word u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        back_w = store_q[i_q - {2'b00, nk_q}];
        if (phase_q == 3'd0) begin
            temp_w = sub_out ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && phase_q == 3'd4) begin
            temp_w = sub_out;
        end else begin
            temp_w = prev_w;
        end
        new_w = back_w ^ temp_w;
    end

    // ---- control FSM ----
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        phase_d    = phase_q;
        rcon_d     = rcon_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load_key   = 1'b0;
        wr_word    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (mode_ok) begin
                        state_d    = S_EXPAND;
                        nk_d       = nk_of(bus.key_mode);
                        nr_d       = nr_of(bus.key_mode);
                        i_d        = {2'b00, nk_of(bus.key_mode)};
                        phase_d    = 3'd0;
                        rcon_d     = 8'h01;
                        rk_valid_d = 1'b0;
                        load_key   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                wr_word = 1'b1;
                i_d     = i_q + 6'd1;
                // Phase tracks i mod Nk without a divider.
                phase_d = (phase_q == 3'(nk_q - 4'd1)) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == last_idx) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    rk_valid_d = 1'b1;
                end
            end
        endcase
    end

    // ---- round-key store ----
    always_comb begin
        store_d = store_q;
        if (load_key) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                if (j < int'(nk_d)) begin
                    store_d[j] = bus.key[MAX_KEY_BITS-1-32*j -: 32];
                end
            end
        end
        if (wr_word) begin
            store_d[i_q] = new_w;
        end
    end

    // ---- read port ----
    always_comb begin
        rd_base = {bus.rk_idx, 2'b00};
        rk_d    = '0;
        if (rk_valid_q && (bus.rk_idx <= nr_q)) begin
            rk_d = {store_q[rd_base], store_q[rd_base + 6'd1],
                    store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            phase_q    <= '0;
            rcon_q     <= 8'h01;
            nk_q       <= 4'd4;
            nr_q       <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rk_q       <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            phase_q    <= phase_d;
            rcon_q     <= rcon_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rk_q       <= rk_d;
        end
    end

    // Store contents survive reset; rk_valid gates every read.
    always_ff @(posedge clk) begin
        store_q <= store_d;
    end

    assign bus.busy     = (state_q == S_EXPAND);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rk_valid = rk_valid_q;
    assign bus.nr       = nr_q;
    assign bus.rk       = rk_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using the FIPS-197 appendix A key expansions.
module tb_aes_key_sched;

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_sched_if #(.MAX_KEY_BITS(256)) b256 ();
    aes_key_sched_if #(.MAX_KEY_BITS(128)) b128 ();

    aes_key_sched #(.MAX_KEY_BITS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b256)
    );

    aes_key_sched #(.MAX_KEY_BITS(128)) dut128 (
        .clk (clk),
        .rst (rst),
        .bus (b128)
    );

    int   total = 0;
    int   bad   = 0;
    int   c256;
    logic err_seen;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%032h expected=%032h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after the accept edge; c256 = edges from accept until done seen.
    task automatic run_expand(input int inject_at);
        c256     = -1;
        err_seen = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            b256.start = (c == inject_at);
            @(posedge clk);
            #1;
            err_seen = err_seen | b256.err;
            if (b256.done === 1'b1) begin
                c256 = c;
                break;
            end
        end
        b256.start = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        b256.start    = 1'b0;
        b256.key_mode = 2'd0;
        b256.key      = '0;
        b256.rk_idx   = 4'd0;
        b128.start    = 1'b0;
        b128.key_mode = 2'd0;
        b128.key      = '0;
        b128.rk_idx   = 4'd0;
        step(3);

        chk1("rst_busy", b256.busy, 1'b0);
        chk1("rst_done", b256.done, 1'b0);
        chk1("rst_err", b256.err, 1'b0);
        chk1("rst_rk_valid", b256.rk_valid, 1'b0);
        chk4("rst_nr", b256.nr, 4'd0);
        chk128("rst_rk", b256.rk, 128'h0);
        rst = 1'b0;
        step(1);

        // AES-128 on both instances
        b256.key      = {K128, 128'h0};
        b256.key_mode = 2'd0;
        b256.start    = 1'b1;
        b128.key      = K128;
        b128.key_mode = 2'd0;
        b128.start    = 1'b1;
        step(1);
        b256.start = 1'b0;
        b128.start = 1'b0;
        chk1("a128_busy", b256.busy, 1'b1);
        chk1("a128_rkv_low", b256.rk_valid, 1'b0);
        run_expand(0);
        chki("a128_done_cyc", c256, 40);
        chk1("a128_busy_end", b256.busy, 1'b0);
        chk1("a128_rk_valid", b256.rk_valid, 1'b1);
        chk4("a128_nr", b256.nr, 4'd10);
        chk1("a128_done_128inst", b128.done, 1'b1);
        b256.rk_idx = 4'd10;
        b128.rk_idx = 4'd10;
        step(1);
        chk1("a128_done_pulse", b256.done, 1'b0);
        chk128("a128_rk10", b256.rk, R128_10);
        chk128("a128_rk10_128inst", b128.rk, R128_10);
        b256.rk_idx = 4'd0;
        step(1);
        chk128("a128_rk0", b256.rk, K128);

        // AES-192 with a foreign start injected mid-expansion
        b256.key      = {K192, 64'h0};
        b256.key_mode = 2'd1;
        b256.start    = 1'b1;
        step(1);
        b256.start    = 1'b0;
        b256.key      = {256{1'b1}};
        b256.key_mode = 2'd0;
        chk1("a192_rkv_low", b256.rk_valid, 1'b0);
        run_expand(10);
        chki("a192_done_cyc", c256, 46);
        chk1("a192_no_err", err_seen, 1'b0);
        chk4("a192_nr", b256.nr, 4'd12);
        b256.rk_idx = 4'd12;
        step(1);
        chk128("a192_rk12", b256.rk, R192_12);

        // AES-256
        b256.key      = K256;
        b256.key_mode = 2'd2;
        b256.start    = 1'b1;
        step(1);
        b256.start = 1'b0;
        run_expand(0);
        chki("a256_done_cyc", c256, 52);
        chk4("a256_nr", b256.nr, 4'd14);
        b256.rk_idx = 4'd14;
        step(1);
        chk128("a256_rk14", b256.rk, R256_14);
        b256.rk_idx = 4'd15;
        step(1);
        chk128("a256_rk15", b256.rk, 128'h0);

        // Reserved mode rejected, schedule retained
        b256.rk_idx   = 4'd14;
        b256.key_mode = 2'd3;
        b256.start    = 1'b1;
        step(1);
        b256.start = 1'b0;
        chk1("rej3_err", b256.err, 1'b1);
        chk1("rej3_busy", b256.busy, 1'b0);
        chk1("rej3_rkv", b256.rk_valid, 1'b1);
        chk4("rej3_nr", b256.nr, 4'd14);
        step(1);
        chk1("rej3_err_pulse", b256.err, 1'b0);
        chk1("rej3_busy2", b256.busy, 1'b0);
        chk128("rej3_rk14", b256.rk, R256_14);

        // AES-256 on a 128-bit-only instance rejected
        b128.key_mode = 2'd2;
        b128.start    = 1'b1;
        step(1);
        b128.start = 1'b0;
        chk1("rej128_err", b128.err, 1'b1);
        chk1("rej128_busy", b128.busy, 1'b0);
        chk1("rej128_rkv", b128.rk_valid, 1'b1);
        chk4("rej128_nr", b128.nr, 4'd10);
        step(1);
        chk1("rej128_err_pulse", b128.err, 1'b0);
        chk128("rej128_rk10", b128.rk, R128_10);

        // Reset in the middle of an AES-256 expansion
        b256.key      = K256;
        b256.key_mode = 2'd2;
        b256.start    = 1'b1;
        step(1);
        b256.start = 1'b0;
        step(19);
        chk1("mid_busy", b256.busy, 1'b1);
        chk4("mid_nr", b256.nr, 4'd14);
        rst = 1'b1;
        #1;
        chk1("mid_rst_busy", b256.busy, 1'b0);
        chk1("mid_rst_done", b256.done, 1'b0);
        chk1("mid_rst_err", b256.err, 1'b0);
        chk1("mid_rst_rkv", b256.rk_valid, 1'b0);
        chk4("mid_rst_nr", b256.nr, 4'd0);
        chk128("mid_rst_rk", b256.rk, 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        b256.key      = {K128, 128'h0};
        b256.key_mode = 2'd0;
        b256.start    = 1'b1;
        step(1);
        b256.start = 1'b0;
        run_expand(0);
        chki("post_rst_done_cyc", c256, 40);
        chk4("post_rst_nr", b256.nr, 4'd10);
        b256.rk_idx = 4'd10;
        step(1);
        chk128("post_rst_rk10", b256.rk, R128_10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
